// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - Lock/ready inputs and reset/enable/status outputs of the reset sequencer
interface reset_sequencer_if;
  logic       pll_lock;
  logic       cap_ready;
  logic       acq_ready;
  logic       reset_o;
  logic       cap_en_o;
  logic       acq_en_o;
  logic       cor_en_o;
  logic [2:0] state_o;
  logic       fault_o;

  // Sequencer side
  modport master (
    input  pll_lock, cap_ready, acq_ready,
    output reset_o, cap_en_o, acq_en_o, cor_en_o, state_o, fault_o
  );

  // Clock block / subsystem side
  modport slave (
    output pll_lock, cap_ready, acq_ready,
    input  reset_o, cap_en_o, acq_en_o, cor_en_o, state_o, fault_o
  );
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - PLL-lock gated reset and staged enable sequencer (optional watchdog: RESET_SEQ_WATCHDOG_EN)
module reset_sequencer #(
  parameter int LOCK_CYCLES = 16,
  parameter int STAGE_DELAY = 8,
  parameter int TIMEOUT     = 255,
  parameter int CWIDTH      = 8
) (
  input  logic                clock,
  input  logic                areset_n,
  reset_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_RESET     = 3'd1,
    ST_CAP       = 3'd2,
    ST_ACQ       = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  // Terminal counter values: a transition fires on the edge the count would reach N.
  localparam logic [CWIDTH-1:0] LOCK_LAST  = CWIDTH'(LOCK_CYCLES - 1);
  localparam logic [CWIDTH-1:0] DELAY_LAST = CWIDTH'(STAGE_DELAY - 1);
  localparam logic [CWIDTH-1:0] TO_LAST    = CWIDTH'(TIMEOUT - 1);

  state_t            state, state_nxt;
  logic [CWIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic              sync1, lock_s;
  logic              reset_q, cap_en_q, acq_en_q, cor_en_q;
`ifdef RESET_SEQ_WATCHDOG_EN
  logic              fault_q;
`endif

  // Two-flop synchroniser for the asynchronous PLL lock
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      sync1  <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      sync1  <= bus.pll_lock;
      lock_s <= sync1;
    end
  end

  assign cnt_inc = (cnt == {CWIDTH{1'b1}}) ? cnt : cnt + 1'b1;

  // Next-state and counter; lock loss outranks ready and counter expiry
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_WAIT_LOCK: if (lock_s && cnt == LOCK_LAST) state_nxt = ST_RESET;
      ST_RESET: begin
        if (!lock_s)                state_nxt = ST_WAIT_LOCK;
        else if (cnt == DELAY_LAST) state_nxt = ST_CAP;
      end
      ST_CAP: begin
        if (!lock_s)            state_nxt = ST_WAIT_LOCK;
        else if (bus.cap_ready) state_nxt = ST_ACQ;
`ifdef RESET_SEQ_WATCHDOG_EN
        else if (cnt == TO_LAST) state_nxt = ST_FAULT;
`endif
      end
      ST_ACQ: begin
        if (!lock_s)            state_nxt = ST_WAIT_LOCK;
        else if (bus.acq_ready) state_nxt = ST_RUN;
`ifdef RESET_SEQ_WATCHDOG_EN
        else if (cnt == TO_LAST) state_nxt = ST_FAULT;
`endif
      end
      ST_RUN: if (!lock_s) state_nxt = ST_WAIT_LOCK;
`ifdef RESET_SEQ_WATCHDOG_EN
      ST_FAULT: state_nxt = ST_FAULT;
`endif
      default: state_nxt = ST_WAIT_LOCK;
    endcase

    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else begin
      case (state)
        ST_WAIT_LOCK: cnt_nxt = lock_s ? cnt_inc : '0;
        ST_RESET:     cnt_nxt = cnt_inc;
        // The wait counter parks at its terminal value when no watchdog consumes it.
        ST_CAP,
        ST_ACQ:       cnt_nxt = (cnt == TO_LAST) ? cnt : cnt_inc;
        default:      cnt_nxt = '0;
      endcase
    end
  end

  // State, counter and outputs registered together, outputs decoded from the next state
  always_ff @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      state    <= ST_WAIT_LOCK;
      cnt      <= '0;
      reset_q  <= 1'b1;
      cap_en_q <= 1'b0;
      acq_en_q <= 1'b0;
      cor_en_q <= 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      reset_q  <= state_nxt inside {ST_WAIT_LOCK, ST_RESET, ST_FAULT};
      cap_en_q <= state_nxt inside {ST_CAP, ST_ACQ, ST_RUN};
      acq_en_q <= state_nxt inside {ST_ACQ, ST_RUN};
      cor_en_q <= (state_nxt == ST_RUN);
`ifdef RESET_SEQ_WATCHDOG_EN
      fault_q  <= (state_nxt == ST_FAULT);
`endif
    end
  end

  assign bus.reset_o  = reset_q;
  assign bus.cap_en_o = cap_en_q;
  assign bus.acq_en_o = acq_en_q;
  assign bus.cor_en_o = cor_en_q;
  assign bus.state_o  = state;
`ifdef RESET_SEQ_WATCHDOG_EN
  assign bus.fault_o  = fault_q;
`else
  assign bus.fault_o  = 1'b0;
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - Randomised and directed bench for reset_sequencer against a dwell-time model
module tb_reset_sequencer;

  localparam int LOCK_CYCLES = 16;
  localparam int STAGE_DELAY = 8;
  localparam int TIMEOUT     = 32;
`ifdef RESET_SEQ_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic clock = 1'b0;
  logic areset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  reset_sequencer_if bus();

  reset_sequencer #(
    .LOCK_CYCLES(LOCK_CYCLES), .STAGE_DELAY(STAGE_DELAY), .TIMEOUT(TIMEOUT), .CWIDTH(8)
  ) dut (
    .clock(clock), .areset_n(areset_n), .bus(bus)
  );

  always #5 clock = ~clock;

  // Reference model: phase number, consecutive lock_s run, cycles spent in the phase
  typedef struct packed { int st; int run; int dwell; } mstate_t;
  mstate_t m;
  bit m_s1, m_ls;

  function automatic mstate_t step(mstate_t cur, bit ls, bit cr, bit ar);
    mstate_t n;
    int want;
    n = cur;
    want = cur.st;
    case (cur.st)
      0: begin
        n.run = ls ? cur.run + 1 : 0;
        if (n.run >= LOCK_CYCLES) want = 1;
      end
      1: if (!ls) want = 0; else if (cur.dwell + 1 >= STAGE_DELAY) want = 2;
      2: if (!ls) want = 0; else if (cr) want = 3; else if (WD && cur.dwell + 1 >= TIMEOUT) want = 5;
      3: if (!ls) want = 0; else if (ar) want = 4; else if (WD && cur.dwell + 1 >= TIMEOUT) want = 5;
      4: if (!ls) want = 0;
      default: want = cur.st;
    endcase
    if (want != cur.st) begin
      n.st = want; n.dwell = 0; n.run = 0;
    end else begin
      n.dwell = cur.dwell + 1;
    end
    return n;
  endfunction

  always @(posedge clock or negedge areset_n) begin
    if (!areset_n) begin
      m    <= '{st: 0, run: 0, dwell: 0};
      m_s1 <= 1'b0;
      m_ls <= 1'b0;
    end else begin
      m    <= step(m, m_ls, bus.cap_ready, bus.acq_ready);
      m_s1 <= bus.pll_lock;
      m_ls <= m_s1;
    end
  end

  // {reset, cap_en, acq_en, cor_en, fault, state}
  function automatic logic [7:0] exp_vec(int st);
    logic r, c, a, o, f;
    r = (st == 0) || (st == 1) || (st == 5);
    c = (st >= 2) && (st <= 4);
    a = (st == 3) || (st == 4);
    o = (st == 4);
    f = (st == 5);
    return {r, c, a, o, f, 3'(st)};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {bus.reset_o, bus.cap_en_o, bus.acq_en_o, bus.cor_en_o, bus.fault_o, bus.state_o};
  endfunction

  task automatic wait_state(input int s, input int budget, input string name);
    int n;
    n = 0;
    while (bus.state_o !== 3'(s) && n < budget) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (bus.state_o !== 3'(s)) begin
      failures++;
      $display("FAIL %s: state_o=%0d expected %0d within %0d cycles", name, bus.state_o, s, budget);
    end
  endtask

  task automatic restart_locked();
    @(negedge clock);
    areset_n = 1'b0;
    bus.pll_lock = 1'b1; bus.cap_ready = 1'b0; bus.acq_ready = 1'b0;
    @(negedge clock);
    areset_n = 1'b1;
  endtask

  task automatic bring_to_cap(input string name);
    restart_locked();
    wait_state(2, 60, name);
  endtask

  task automatic test_reset();
    bus.pll_lock = 1'b0; bus.cap_ready = 1'b0; bus.acq_ready = 1'b0;
    @(negedge clock);
    areset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== 8'b1000_0000) begin
      failures++; $display("FAIL reset_values: got %b expected %b", dut_vec(), 8'b1000_0000);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (dut_vec() !== 8'b1000_0000) begin
      failures++; $display("FAIL reset_held: got %b expected %b", dut_vec(), 8'b1000_0000);
    end
  endtask

  task automatic test_power_up();
    int n0, n1;
    logic [7:0] prev;
    restart_locked();
    n0 = 0;
    do begin @(negedge clock); n0++; end while (bus.state_o == 3'd0 && n0 < 100);
    checks++;
    if (n0 !== 18) begin failures++; $display("FAIL wait_lock_cycles: got %0d expected 18", n0); end
    n1 = 0;
    do begin prev = dut_vec(); @(negedge clock); n1++; end while (bus.state_o == 3'd1 && n1 < 100);
    checks++;
    if (n1 !== 8) begin failures++; $display("FAIL reset_stage_cycles: got %0d expected 8", n1); end
    checks++;
    if (prev !== exp_vec(1) || dut_vec() !== exp_vec(2)) begin
      failures++;
      $display("FAIL cap_enable_edge: got %b then %b expected %b then %b", prev, dut_vec(), exp_vec(1), exp_vec(2));
    end
  endtask

  task automatic test_lock_glitch();
    int n;
    restart_locked();
    repeat (10) @(negedge clock);
    bus.pll_lock = 1'b0;
    @(negedge clock);
    bus.pll_lock = 1'b1;
    n = 11;
    while (bus.state_o == 3'd0 && n < 100) begin @(negedge clock); n++; end
    checks++;
    if (n !== 29) begin failures++; $display("FAIL lock_glitch_restart: reset entered after %0d cycles expected 29", n); end
  endtask

  task automatic test_handshake();
    bring_to_cap("hs_reach_cap");
    repeat (4) @(negedge clock);
    bus.cap_ready = 1'b1;
    @(negedge clock);
    bus.cap_ready = 1'b0;
    checks++;
    if (dut_vec() !== exp_vec(3)) begin failures++; $display("FAIL cap_ready_to_acq: got %b expected %b", dut_vec(), exp_vec(3)); end
    repeat (2) @(negedge clock);
    bus.acq_ready = 1'b1;
    @(negedge clock);
    bus.acq_ready = 1'b0;
    checks++;
    if (dut_vec() !== exp_vec(4)) begin failures++; $display("FAIL acq_ready_to_run: got %b expected %b", dut_vec(), exp_vec(4)); end
    bus.cap_ready = 1'b1; bus.acq_ready = 1'b1;
    repeat (3) @(negedge clock);
    bus.cap_ready = 1'b0; bus.acq_ready = 1'b0;
    checks++;
    if (dut_vec() !== exp_vec(4)) begin failures++; $display("FAIL run_ignores_ready: got %b expected %b", dut_vec(), exp_vec(4)); end
  endtask

  task automatic test_lock_priority();
    bring_to_cap("prio_reach_cap");
    bus.pll_lock = 1'b0;
    repeat (2) @(negedge clock);
    bus.cap_ready = 1'b1;
    @(negedge clock);
    bus.cap_ready = 1'b0;
    checks++;
    if (dut_vec() !== exp_vec(0)) begin failures++; $display("FAIL lock_loss_beats_ready: got %b expected %b", dut_vec(), exp_vec(0)); end
  endtask

  task automatic test_run_lock_loss();
    int n;
    bring_to_cap("run_reach_cap");
    bus.cap_ready = 1'b1; @(negedge clock); bus.cap_ready = 1'b0;
    bus.acq_ready = 1'b1; @(negedge clock); bus.acq_ready = 1'b0;
    wait_state(4, 4, "run_reached");
    bus.pll_lock = 1'b0;
    n = 0;
    while (bus.state_o != 3'd0 && n < 10) begin @(negedge clock); n++; end
    checks++;
    if (n > 3 || dut_vec() !== exp_vec(0)) begin
      failures++; $display("FAIL run_lock_loss: %0d cycles, got %b expected <=3 cycles and %b", n, dut_vec(), exp_vec(0));
    end
    @(negedge clock);
    bus.pll_lock = 1'b1;
    n = 0;
    do begin @(negedge clock); n++; end while (bus.state_o == 3'd0 && n < 100);
    checks++;
    if (n !== 18) begin failures++; $display("FAIL relock_wait_cycles: got %0d expected 18", n); end
    wait_state(2, 20, "relock_reach_cap");
  endtask

  task automatic test_watchdog();
    int n;
    bring_to_cap("wd_reach_cap");
`ifdef RESET_SEQ_WATCHDOG_EN
    n = 1;
    forever begin
      @(negedge clock);
      if (bus.state_o != 3'd2 || n >= 200) break;
      n++;
    end
    checks++;
    if (n !== 32 || dut_vec() !== exp_vec(5)) begin
      failures++; $display("FAIL watchdog_timeout: %0d cap cycles got %b expected 32 and %b", n, dut_vec(), exp_vec(5));
    end
    repeat (20) begin @(negedge clock); bus.pll_lock = 1'($urandom_range(0, 1)); end
    repeat (3) @(negedge clock);
    checks++;
    if (dut_vec() !== exp_vec(5)) begin failures++; $display("FAIL fault_sticky: got %b expected %b", dut_vec(), exp_vec(5)); end
    areset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== exp_vec(0)) begin failures++; $display("FAIL fault_cleared: got %b expected %b", dut_vec(), exp_vec(0)); end
    @(negedge clock);
    areset_n = 1'b1;
`else
    n = 0;
    repeat (1100) begin
      @(negedge clock);
      if (dut_vec() === exp_vec(2)) n++;
    end
    checks++;
    if (n !== 1100) begin failures++; $display("FAIL cap_waits_forever: %0d of 1100 cycles in cap expected 1100", n); end
`endif
  endtask

  task automatic test_async_reset_mid_acq();
    bring_to_cap("async_reach_cap");
    bus.cap_ready = 1'b1; @(negedge clock); bus.cap_ready = 1'b0;
    @(posedge clock);
    #2 areset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== exp_vec(0)) begin failures++; $display("FAIL async_reset_mid_acq: got %b expected %b", dut_vec(), exp_vec(0)); end
    @(negedge clock);
    areset_n = 1'b1;
    repeat (40) begin
      @(negedge clock);
      checks++;
      if (dut_vec() !== exp_vec(m.st)) begin
        failures++; $display("FAIL restart_model: got %b expected %b", dut_vec(), exp_vec(m.st));
      end
    end
  endtask

  task automatic test_random();
    int lo_left;
    lo_left = 0;
    @(negedge clock);
    areset_n = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clock);
      checks++;
      if (dut_vec() !== exp_vec(m.st)) begin
        failures++; $display("FAIL random_cycle_%0d: got %b expected %b", i, dut_vec(), exp_vec(m.st));
      end
      areset_n = (i % 700 == 699) ? 1'b0 : 1'b1;
      if (lo_left > 0) begin
        bus.pll_lock = 1'b0; lo_left--;
      end else if ($urandom_range(0, 149) == 0) begin
        bus.pll_lock = 1'b0; lo_left = $urandom_range(0, 3);
      end else begin
        bus.pll_lock = 1'b1;
      end
      bus.cap_ready = ($urandom_range(0, 24) == 0);
      bus.acq_ready = ($urandom_range(0, 24) == 0);
    end
    bus.cap_ready = 1'b0; bus.acq_ready = 1'b0;
  endtask

  initial begin
    bus.pll_lock = 1'b0; bus.cap_ready = 1'b0; bus.acq_ready = 1'b0;
    test_reset();
    test_power_up();
    test_lock_glitch();
    test_handshake();
    test_lock_priority();
    test_run_lock_loss();
    test_watchdog();
    test_async_reset_mid_acq();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
